euc_mc: RTL

//  Parametrised multi-cycle execution unit controller. Accepts one decoded instruction at a time from fetch
//  (valid/ready), drives the execution data path (ALU op, operand/const muxes, per-register write enables,

---
 rtl/euc_pkg.sv | 40 ++++
 rtl/euc_mem_timer.sv | 35 +++
 rtl/euc_mc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/euc_pkg.sv
// Shared definitions for the euc_mc execution unit controller:
// opcode encodings, ALU operation codes, write-data select codes and
// the controller state encoding.
package euc_pkg;

  // Instruction opcodes as presented by fetch/decode.
  localparam logic [3:0] OP_LD     = 4'd0;
  localparam logic [3:0] OP_AND    = 4'd1;
  localparam logic [3:0] OP_ST     = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_ADDI   = 4'd4;
  localparam logic [3:0] OP_CMPLT  = 4'd5;
  localparam logic [3:0] OP_CMPEQ  = 4'd6;
  localparam logic [3:0] OP_CMPEQI = 4'd7;
  localparam logic [3:0] OP_SHR    = 4'd8;
  localparam logic [3:0] OP_SHL    = 4'd9;
  localparam logic [3:0] OP_INV    = 4'd10;
  localparam logic [3:0] OP_MVI    = 4'd11;

  // ALU operation codes driven to the data path.
  localparam logic [2:0] ALU_AND    = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_INV    = 3'd2;
  localparam logic [2:0] ALU_SHL    = 3'd3;
  localparam logic [2:0] ALU_SHR    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd5;

  // Register write-data source select.
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_IMM = 2'd1;
  localparam logic [1:0] WD_MEM = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/euc_mem_timer.sv
// Memory wait-state timer. Counts cycles while enabled (saturating at
// 255), is cleared synchronously on entry to a memory access, and flags
// expiry on the cycle the count reaches MEM_TIMEOUT-1.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     zero the count (takes priority over enable)
//   enable    count this cycle (controller is in its MEM state)
//   expire    enable is high and the count equals MEM_TIMEOUT-1
module euc_mem_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expire = enable && (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/euc_mc.sv
// Multi-cycle execution unit controller. Accepts one decoded instruction
// at a time from fetch (valid/ready), drives the execution data path
// controls for one EXEC cycle, or runs a load/store against data memory
// with request/ack handshake and timeout. Illegal opcodes, out-of-range
// register indices and memory timeouts finish through a one-cycle ERR state.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   instr_valid_i / instr_ready_o  instruction handshake (ready only in IDLE)
//   opcode_i, src_reg_i, dst_reg_i decoded instruction fields
//   instr_done_o                   pulse on the final cycle of each instruction
//   illegal_o, mem_err_o           error pulses, coincident with done
//   data_mem_rd/wr_enb_o, mem_ack_i data memory request/ack
//   alu_op_o, src_sel_o, dst_sel_o, const_sel_o  data path operand/ALU controls
//   wr_en_o, wr_data_sel_o         one-hot register write enable and data source
//   flag_wr_o, cmp_mode_o          compare flag update and compare kind
module euc_mc
  import euc_pkg::*;
#(
  parameter  int NUM_REGS    = 4,
  parameter  int MEM_TIMEOUT = 15,
  localparam int REG_SEL_W   = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [3:0]           opcode_i,
  input  logic [REG_SEL_W-1:0] src_reg_i,
  input  logic [REG_SEL_W-1:0] dst_reg_i,
  output logic                 instr_done_o,
  output logic                 illegal_o,
  output logic                 mem_err_o,
  output logic                 data_mem_rd_enb_o,
  output logic                 data_mem_wr_enb_o,
  input  logic                 mem_ack_i,
  output logic [2:0]           alu_op_o,
  output logic [REG_SEL_W-1:0] src_sel_o,
  output logic [REG_SEL_W-1:0] dst_sel_o,
  output logic                 const_sel_o,
  output logic [NUM_REGS-1:0]  wr_en_o,
  output logic [1:0]           wr_data_sel_o,
  output logic                 flag_wr_o,
  output logic                 cmp_mode_o
);

  state_t               state, state_nx;
  logic [3:0]           op_q;
  logic [REG_SEL_W-1:0] src_q, dst_q;
  logic                 mem_fail_q;   // ERR was entered from a memory timeout
  logic                 accept, bad_instr, is_mem_op, timer_clear, timer_expire;
  logic [NUM_REGS-1:0]  dst_onehot;

  assign instr_ready_o = (state == ST_IDLE);
  assign accept        = instr_valid_i & instr_ready_o;

  // Register indices are widened so the range check stays meaningful when
  // NUM_REGS is a power of two and the check can never fire.
  assign bad_instr = (opcode_i > OP_MVI)
                  || (5'(src_reg_i) >= 5'(NUM_REGS))
                  || (5'(dst_reg_i) >= 5'(NUM_REGS));
  assign is_mem_op   = (opcode_i == OP_LD) || (opcode_i == OP_ST);
  assign timer_clear = accept & ~bad_instr & is_mem_op;
  assign dst_onehot  = NUM_REGS'(1) << dst_q;

  euc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (state == ST_MEM),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      mem_fail_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= opcode_i;
        src_q <= src_reg_i;
        dst_q <= dst_reg_i;
      end
      if (state_nx == ST_ERR) begin
        mem_fail_q <= (state == ST_MEM);
      end
    end
  end

  // NOTE: every output is given a default before the case statement so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx          = state;
    instr_done_o      = 1'b0;
    illegal_o         = 1'b0;
    mem_err_o         = 1'b0;
    data_mem_rd_enb_o = 1'b0;
    data_mem_wr_enb_o = 1'b0;
    alu_op_o          = ALU_AND;
    src_sel_o         = '0;
    dst_sel_o         = '0;
    const_sel_o       = 1'b0;
    wr_en_o           = '0;
    wr_data_sel_o     = WD_ALU;
    flag_wr_o         = 1'b0;
    cmp_mode_o        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad_instr)      state_nx = ST_ERR;
          else if (is_mem_op) state_nx = ST_MEM;
          else                state_nx = ST_EXEC;
        end
      end

      ST_EXEC: begin
        instr_done_o = 1'b1;
        src_sel_o    = src_q;
        dst_sel_o    = dst_q;
        state_nx     = ST_IDLE;
        case (op_q)
          OP_AND:    begin wr_en_o = dst_onehot; alu_op_o = ALU_AND; end
          OP_ADD:    begin wr_en_o = dst_onehot; alu_op_o = ALU_ADD; end
          OP_ADDI:   begin wr_en_o = dst_onehot; alu_op_o = ALU_ADD; const_sel_o = 1'b1; end
          OP_SHR:    begin wr_en_o = dst_onehot; alu_op_o = ALU_SHR; end
          OP_SHL:    begin wr_en_o = dst_onehot; alu_op_o = ALU_SHL; end
          OP_INV:    begin wr_en_o = dst_onehot; alu_op_o = ALU_INV; end
          OP_MVI: begin
            wr_en_o       = dst_onehot;
            alu_op_o      = ALU_PASS_B;
            wr_data_sel_o = WD_IMM;
            const_sel_o   = 1'b1;
          end
          OP_CMPLT:  begin flag_wr_o = 1'b1; cmp_mode_o = 1'b0; end
          OP_CMPEQ:  begin flag_wr_o = 1'b1; cmp_mode_o = 1'b1; end
          OP_CMPEQI: begin flag_wr_o = 1'b1; cmp_mode_o = 1'b1; const_sel_o = 1'b1; end
          default: ;
        endcase
      end

      ST_MEM: begin
        src_sel_o         = src_q;
        dst_sel_o         = dst_q;
        data_mem_rd_enb_o = (op_q == OP_LD);
        data_mem_wr_enb_o = (op_q == OP_ST);
        // An ack on the expiry cycle still completes the access normally.
        if (mem_ack_i) begin
          instr_done_o = 1'b1;
          if (op_q == OP_LD) begin
            wr_en_o       = dst_onehot;
            wr_data_sel_o = WD_MEM;
          end
          state_nx = ST_IDLE;
        end else if (timer_expire) begin
          state_nx = ST_ERR;
        end
      end

      ST_ERR: begin
        instr_done_o = 1'b1;
        illegal_o    = ~mem_fail_q;
        mem_err_o    = mem_fail_q;
        state_nx     = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
